// File: rtl/spi_slave_0.sv
// spi_slave_0 -- SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames)
// with a two-cycle CPU register port.
//
// All logic runs on clk. SCLK, SS_n and MOSI are oversampled through
// SYNC_STAGES flip-flops, so SCLK must be no faster than clk/8.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   SCLK, SS_n, MOSI    SPI pins from the external master (asynchronous)
//   MISO, MISO_oe       slave data out and its tri-state enable
//   data_from_cpu       CPU write data
//   mem_addr            0 rx data (r), 1 tx data (w), 2 status (r, write clears),
//                       3 control (r/w)
//   read_n, write_n     active-low CPU strobes, qualified by spi_select
//   data_to_cpu         registered read data
//   irq                 registered interrupt
module spi_slave_0 #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [15:0] data_from_cpu,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic [15:0] data_to_cpu,
  output logic        irq
);

  localparam int CW = $clog2(DATABITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s, sclk_d;
  logic start, active, rise, fall, reload;

  logic [DATABITS-1:0] rx_shift, tx_shift, rx_holding, tx_holding;
  logic [CW-1:0]       bitcnt;
  logic                byte_done, skip_fall;

  logic       rd_strobe, wr_strobe;
  logic       rx_read, tx_write, st_clear, ctl_write, tx_accept;
  logic       rrdy, roe, toe, tur, primed, err;
  logic [5:0] ctrl;
  logic [15:0] status;
  logic       unused_bits;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Pin synchronisers; SS_n resets high so the slave comes up deselected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      MISO_oe   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      MISO_oe   <= ~ss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state; start pulses for the one cycle the frame opens.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_s) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_s) state_next = IDLE;
        else      state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign active = (state == ACTIVE) & ~ss_s;
  assign rise   = active & sclk_s & ~sclk_d;
  assign fall   = active & ~sclk_s & sclk_d;
  // The tx shifter is refilled at frame open and right after each full byte.
  assign reload = start | byte_done;

  // Shift registers and bit counter.
  // After a byte-end reload the very next SCLK fall closes the old frame's
  // last bit; shifting there would lose bit 7 of the new byte, so it is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift  <= '0;
      tx_shift  <= '0;
      bitcnt    <= '0;
      byte_done <= 1'b0;
      skip_fall <= 1'b0;
    end else begin
      byte_done <= rise & (bitcnt == LAST_BIT);
      if (start || ((state == ACTIVE) && ss_s)) begin
        bitcnt <= '0;
      end else if (rise) begin
        rx_shift <= {rx_shift[DATABITS-2:0], mosi_s};
        bitcnt   <= bitcnt + CW'(1);
      end
      if (reload) begin
        tx_shift  <= primed ? tx_holding : '0;
        skip_fall <= byte_done;
      end else if (fall) begin
        if (skip_fall) skip_fall <= 1'b0;
        else           tx_shift  <= {tx_shift[DATABITS-2:0], 1'b0};
      end
    end
  end

  assign MISO = tx_shift[DATABITS-1];

  // One strobe per access, even though the CPU holds read_n/write_n two cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      rd_strobe <= spi_select & ~read_n & ~rd_strobe;
      wr_strobe <= spi_select & ~write_n & ~wr_strobe;
    end
  end

  assign rx_read   = rd_strobe & (mem_addr == 3'd0);
  assign tx_write  = wr_strobe & (mem_addr == 3'd1);
  assign st_clear  = wr_strobe & (mem_addr == 3'd2);
  assign ctl_write = wr_strobe & (mem_addr == 3'd3);
  // A reload in the same cycle frees the holding register for the CPU byte.
  assign tx_accept = tx_write & (~primed | reload);

  // Status flags, holding registers and control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrdy       <= 1'b0;
      roe        <= 1'b0;
      toe        <= 1'b0;
      tur        <= 1'b0;
      primed     <= 1'b0;
      rx_holding <= '0;
      tx_holding <= '0;
      ctrl       <= 6'd0;
    end else begin
      if (byte_done) begin
        rx_holding <= rx_shift;
        rrdy       <= 1'b1;
      end else if (rx_read || st_clear) begin
        rrdy <= 1'b0;
      end
      // Overrun only if the old byte is not being taken in this very cycle.
      if (byte_done && rrdy && !rx_read && !st_clear) roe <= 1'b1;
      else if (st_clear)                               roe <= 1'b0;
      if (reload && !primed) tur <= 1'b1;
      else if (st_clear)     tur <= 1'b0;
      if (tx_write && !tx_accept) toe <= 1'b1;
      else if (st_clear)          toe <= 1'b0;
      if (tx_accept) begin
        tx_holding <= data_from_cpu[DATABITS-1:0];
        primed     <= 1'b1;
      end else if (reload) begin
        primed <= 1'b0;
      end
      if (ctl_write) ctrl <= data_from_cpu[8:3];
    end
  end

  assign err    = roe | toe | tur;
  assign status = {6'd0, ~ss_s, err, rrdy, ~primed, tur, toe, roe, 3'd0};
  assign unused_bits = ^data_from_cpu[15:9];

  // Registered read mux and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= 16'd0;
      irq         <= 1'b0;
    end else begin
      case (mem_addr)
        3'd0:    data_to_cpu <= {{(16-DATABITS){1'b0}}, rx_holding};
        3'd2:    data_to_cpu <= status;
        3'd3:    data_to_cpu <= {7'd0, ctrl, 3'd0};
        default: data_to_cpu <= 16'd0;
      endcase
      irq <= |(status[8:3] & ctrl);
    end
  end

endmodule
